// File: rtl/matrix_collector.sv
`default_nettype none
// ============================================================================
// Module   : matrix_collector
// Brief    : Collects ROWS 4-lane beats into a ROWSx4 matrix and hands it to
//            writeback over valid/ready. Single-buffered, sticky overrun flag.
//            Optional macro COLLECTOR_TRANSPOSE_EN stores lanes as columns.
// Revision : 1.0 - initial release
// ============================================================================
module matrix_collector #(
    parameter int DW   = 32,
    parameter int ROWS = 4,
    localparam int CW  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DW-1:0]          d1,
    input  logic [DW-1:0]          d2,
    input  logic [DW-1:0]          d3,
    input  logic [DW-1:0]          d4,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ROWS*4*DW-1:0]   m_flat,
    output logic [CW-1:0]          beat_cnt,
    output logic                   err
);

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic [ROWS*4*DW-1:0]   m_flat_q, m_flat_d;

    logic [DW-1:0]          w_lane [4];
    int                     w_idx  [4];
    logic                   w_accept;
    logic                   w_release;
    logic                   w_last;

    assign w_lane[0] = d1;
    assign w_lane[1] = d2;
    assign w_lane[2] = d3;
    assign w_lane[3] = d4;

`ifdef COLLECTOR_TRANSPOSE_EN
    // Column store only makes sense for a square 4x4 matrix.
    generate
        if (ROWS != 4) begin : g_rows_chk
            $error("matrix_collector: COLLECTOR_TRANSPOSE_EN requires ROWS == 4");
        end
    endgenerate

    generate
        for (genvar k = 0; k < 4; k++) begin : g_lane_idx
            assign w_idx[k] = 4 * k + int'(cnt_q);
        end
    endgenerate
`else
    generate
        for (genvar k = 0; k < 4; k++) begin : g_lane_idx
            assign w_idx[k] = 4 * int'(cnt_q) + k;
        end
    endgenerate
`endif

    // In FULL the consumer's ready passes straight through, so a beat can
    // land in the same cycle the held matrix leaves.
    assign out_valid = (state_q == ST_FULL);
    assign in_ready  = (state_q == ST_FILL) || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_release = out_valid && out_ready;
    assign w_last    = (cnt_q == CW'(ROWS - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        m_flat_d = m_flat_q;

        if (clr) begin
            state_d = ST_FILL;
            cnt_d   = '0;
            err_d   = 1'b0;
        end else begin
            if (in_valid && !in_ready) begin
                err_d = 1'b1;
            end
            // An accept in FULL always coincides with a release, so the
            // same row-write path serves both states.
            if (w_accept) begin
                for (int k = 0; k < 4; k++) begin
                    m_flat_d[w_idx[k]*DW +: DW] = w_lane[k];
                end
                if (w_last) begin
                    cnt_d   = '0;
                    state_d = ST_FULL;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    state_d = ST_FILL;
                end
            end else if (w_release) begin
                state_d = ST_FILL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_FILL;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            m_flat_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            m_flat_q <= m_flat_d;
        end
    end

    assign m_flat   = m_flat_q;
    assign beat_cnt = cnt_q;
    assign err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_matrix_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_collector
// Brief    : Self-checking bench for matrix_collector (default row-major build)
//            with a frame-level reference model and randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_collector;

    localparam int DW   = 32;
    localparam int ROWS = 4;
    localparam int NW   = ROWS * 4;
    localparam int MW   = NW * DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] d1 = '0, d2 = '0, d3 = '0, d4 = '0;
    logic          in_ready;
    logic          out_valid;
    logic [MW-1:0] m_flat;
    logic [1:0]    beat_cnt;
    logic          err;

    matrix_collector #(.DW(DW), .ROWS(ROWS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .d4        (d4),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .m_flat    (m_flat),
        .beat_cnt  (beat_cnt),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Reference model: matrix words, beats gathered in the current frame,
    // whether a finished frame is held, and the sticky overrun flag.
    logic [DW-1:0] mdl_mat [NW];
    int            mdl_n;
    bit            mdl_full;
    bit            mdl_err;
    bit            cmp_en = 1'b0;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [MW-1:0] mdl_flat();
        logic [MW-1:0] f;
        for (int i = 0; i < NW; i++) f[i*DW +: DW] = mdl_mat[i];
        return f;
    endfunction

    task automatic mdl_reset();
        mdl_n    = 0;
        mdl_full = 1'b0;
        mdl_err  = 1'b0;
        for (int i = 0; i < NW; i++) mdl_mat[i] = '0;
    endtask

    task automatic model_step();
        bit acc;
        acc = in_valid && (!mdl_full || out_ready);
        if (clr) begin
            mdl_n    = 0;
            mdl_full = 1'b0;
            mdl_err  = 1'b0;
        end else begin
            if (in_valid && !acc) mdl_err = 1'b1;
            if (mdl_full && out_ready) mdl_full = 1'b0;
            if (acc) begin
                mdl_mat[4*mdl_n + 0] = d1;
                mdl_mat[4*mdl_n + 1] = d2;
                mdl_mat[4*mdl_n + 2] = d3;
                mdl_mat[4*mdl_n + 3] = d4;
                mdl_n++;
                if (mdl_n == ROWS) begin
                    mdl_n    = 0;
                    mdl_full = 1'b1;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            chk("out_valid", MW'(out_valid), MW'(mdl_full));
            chk("in_ready",  MW'(in_ready),  MW'(!mdl_full || out_ready));
            chk("beat_cnt",  MW'(beat_cnt),  MW'(mdl_n));
            chk("err",       MW'(err),       MW'(mdl_err));
            chk("m_flat",    m_flat,         mdl_flat());
        end
    end

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic beat(input logic [DW-1:0] a, b, c, e);
        in_valid = 1'b1;
        d1 = a; d2 = b; d3 = c; d4 = e;
        cycle();
        in_valid = 1'b0;
    endtask

    initial begin
        mdl_reset();
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        cmp_en = 1'b1;

        chk("rst_out_valid", MW'(out_valid), MW'(0));
        chk("rst_in_ready",  MW'(in_ready),  MW'(1));
        chk("rst_beat_cnt",  MW'(beat_cnt),  MW'(0));
        chk("rst_err",       MW'(err),       MW'(0));
        chk("rst_m_flat",    m_flat,         MW'(0));

        // Basic fill: element (r,k) = 4r+k
        out_ready = 1'b0;
        for (int r = 0; r < ROWS; r++)
            beat(DW'(4*r), DW'(4*r+1), DW'(4*r+2), DW'(4*r+3));
        chk("t1_out_valid", MW'(out_valid), MW'(1));
        chk("t1_in_ready",  MW'(in_ready),  MW'(0));
        chk("t1_beat_cnt",  MW'(beat_cnt),  MW'(0));
        chk("t1_word1",     MW'(m_flat[1*DW +: DW]),  MW'(1));
        chk("t1_word4",     MW'(m_flat[4*DW +: DW]),  MW'(4));
        chk("t1_word15",    MW'(m_flat[15*DW +: DW]), MW'(15));

        // Overrun while held
        beat(32'hDEAD, 32'h0, 32'h0, 32'h0);
        chk("t2_err",       MW'(err),       MW'(1));
        chk("t2_word0",     MW'(m_flat[0 +: DW]), MW'(0));
        chk("t2_out_valid", MW'(out_valid), MW'(1));
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        chk("t2_rel_valid", MW'(out_valid), MW'(0));
        chk("t2_err_stick", MW'(err),       MW'(1));

        // Release and accept in the same cycle
        for (int r = 0; r < ROWS; r++)
            beat(DW'(100+4*r), DW'(101+4*r), DW'(102+4*r), DW'(103+4*r));
        out_ready = 1'b1;
        beat(32'h3f800000, 32'h3f800000, 32'h3f800000, 32'h3f800000);
        out_ready = 1'b0;
        chk("t3_out_valid", MW'(out_valid), MW'(0));
        chk("t3_beat_cnt",  MW'(beat_cnt),  MW'(1));
        chk("t3_row0",      MW'(m_flat[0 +: 4*DW]), MW'({4{32'h3f800000}}));
        chk("t3_row1_kept", MW'(m_flat[4*DW +: DW]), MW'(104));

        // Reset mid-frame
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        beat(32'h11, 32'h12, 32'h13, 32'h14);
        beat(32'h21, 32'h22, 32'h23, 32'h24);
        rst_n = 1'b0;
        #1;
        chk("t4_rst_valid", MW'(out_valid), MW'(0));
        chk("t4_rst_cnt",   MW'(beat_cnt),  MW'(0));
        chk("t4_rst_mflat", m_flat,         MW'(0));
        mdl_reset();
        #1 rst_n = 1'b1;
        for (int r = 0; r < ROWS; r++)
            beat(DW'(32'hA0+4*r), DW'(32'hA1+4*r), DW'(32'hA2+4*r), DW'(32'hA3+4*r));
        chk("t4_valid",  MW'(out_valid), MW'(1));
        chk("t4_word0",  MW'(m_flat[0 +: DW]),     MW'(32'hA0));
        chk("t4_word15", MW'(m_flat[15*DW +: DW]), MW'(32'hAF));

        // Set err, release, then clr on the final beat
        beat(32'h5, 32'h5, 32'h5, 32'h5);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        chk("t5_err_pre", MW'(err), MW'(1));
        for (int r = 0; r < ROWS-1; r++)
            beat(DW'(r), DW'(r), DW'(r), DW'(r));
        clr = 1'b1;
        beat(32'h77, 32'h77, 32'h77, 32'h77);
        clr = 1'b0;
        chk("t5_out_valid", MW'(out_valid), MW'(0));
        chk("t5_beat_cnt",  MW'(beat_cnt),  MW'(0));
        chk("t5_err",       MW'(err),       MW'(0));

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 1) != 0);
            clr       = ($urandom_range(0, 63) == 0);
            d1 = $urandom; d2 = $urandom; d3 = $urandom; d4 = $urandom;
            cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clr       = 1'b0;
        cycle();
        cmp_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
